processor_fetch_queue: RTL and testbench

Parametrised instruction-fetch stage with a prefetch queue, replacing the single-register fetch stage at the front of the processor pipeline. Issues sequential code-memory reads ahead of the decoder, buffers up to DEPTH fetched {ip, instruction} pairs, and hands them downstream with a valid/ready handshake. On a call or return redirect it flushes the queue, kills any in-flight read and restarts fetch at the target.

---
 rtl/processor_fetch_queue_pkg.sv | 25 ++
 rtl/processor_fetch_queue_fifo.sv | 51 +++++
 rtl/processor_fetch_queue.sv | 125 ++++++++++++
 tb/tb_processor_fetch_queue.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/processor_fetch_queue_pkg.sv
// Shared fetch-stage definitions: default widths and the redirect-priority encoding
// used by this stage and by the later pipeline stages.
package processor_fetch_queue_pkg;

    localparam int DEFAULT_ADDR_SIZE = 18;
    localparam int DEFAULT_WORD_SIZE = 18;
    localparam int DEFAULT_DEPTH     = 4;

    typedef enum logic [1:0] {
        REDIRECT_NONE   = 2'd0,
        REDIRECT_CALL   = 2'd1,
        REDIRECT_RETURN = 2'd2
    } redirect_e;

    // Return outranks call when both fire in the same cycle.
    function automatic redirect_e redirect_select(input logic call, input logic ret);
        if (ret)
            return REDIRECT_RETURN;
        else if (call)
            return REDIRECT_CALL;
        else
            return REDIRECT_NONE;
    endfunction

endpackage

// File: rtl/processor_fetch_queue_fifo.sv
// Synchronous DEPTH-entry FIFO with push, pop, flush and occupancy count.
// Flush takes priority over a push issued in the same cycle.
module processor_fetch_queue_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: the storage is reset so the head output reads zero out of reset instead of X.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/processor_fetch_queue.sv
// Prefetching instruction-fetch stage feeding the decoder through a DEPTH-entry queue.
// Define FETCH_QUEUE_BYPASS_EN to present a response combinationally when the queue is empty.
module processor_fetch_queue
    import processor_fetch_queue_pkg::*;
#(
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int DEPTH     = DEFAULT_DEPTH
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 code_req,
    output logic [ADDR_SIZE-1:0] code_addr,
    input  logic [WORD_SIZE-1:0] code_data,
    input  logic [WORD_SIZE-1:0] ip_to_call,
    input  logic                 call_performed,
    input  logic [WORD_SIZE-1:0] ip_to_return,
    input  logic                 return_performed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_SIZE-1:0] ip_out,
    output logic [WORD_SIZE-1:0] instr_out
);
    localparam int             CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_SIZE-1:0] ip;
        logic [WORD_SIZE-1:0] instr;
    } entry_t;

    redirect_e            redirect_kind;
    logic                 redirect;
    logic [ADDR_SIZE-1:0] target;
    logic [ADDR_SIZE-1:0] fetch_ip;
    logic [ADDR_SIZE-1:0] req_ip;
    logic                 running;
    logic                 inflight;
    logic                 push;
    logic                 pop;
    logic                 fifo_pop;
    logic [CNT_W-1:0]     count;
    logic [CNT_W:0]       occupancy;
    entry_t               head;
    entry_t               response;

    // NOTE: every signal in this block is assigned on every path, so no latch is inferred.
    always_comb begin
        redirect_kind = redirect_select(call_performed, return_performed);
        redirect      = (redirect_kind != REDIRECT_NONE);
        case (redirect_kind)
            REDIRECT_RETURN: target = ip_to_return[ADDR_SIZE-1:0];
            REDIRECT_CALL:   target = ip_to_call[ADDR_SIZE-1:0];
            default:         target = fetch_ip;
        endcase
    end

    assign response = '{ip: req_ip, instr: code_data};

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass_hit;

    // A live response meeting an empty queue skips the FIFO; it is only stored if refused.
    always_comb begin
        bypass_hit = inflight && !redirect && (count == '0);
        out_valid  = bypass_hit || (count != '0);
        ip_out     = bypass_hit ? response.ip    : head.ip;
        instr_out  = bypass_hit ? response.instr : head.instr;
        push       = inflight && !(bypass_hit && out_ready);
    end
`else
    always_comb begin
        out_valid = (count != '0);
        ip_out    = head.ip;
        instr_out = head.instr;
        push      = inflight;
    end
`endif

    assign pop      = out_valid && out_ready;
    assign fifo_pop = out_ready && (count != '0);

    // The in-flight read holds a reserved slot, so the queue can never overflow.
    assign occupancy = (CNT_W + 1)'(count) + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
    assign code_req  = running && !redirect && (occupancy < DEPTH_V);
    assign code_addr = fetch_ip;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            running  <= 1'b0;
            inflight <= 1'b0;
            fetch_ip <= '0;
            req_ip   <= '0;
        end else begin
            running <= 1'b1;
            if (redirect) begin
                fetch_ip <= target;
                inflight <= 1'b0;
            end else begin
                inflight <= code_req;
                if (code_req) begin
                    fetch_ip <= fetch_ip + ADDR_SIZE'(1);
                    req_ip   <= fetch_ip;
                end
            end
        end
    end

    // Redirect drives flush, which also discards the response of a killed read.
    processor_fetch_queue_fifo #(
        .WIDTH($bits(entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (fifo_pop),
        .flush    (redirect),
        .push_data(response),
        .head_data(head),
        .count    (count)
    );

endmodule

// File: tb/tb_processor_fetch_queue.sv
// Bench for processor_fetch_queue: directed redirect vectors, reset/stall corner sequences
// and randomized traffic scored against a queue-based reference model.
module tb_processor_fetch_queue;

    localparam int AW    = 18;
    localparam int WW    = 18;
    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int RESP_LAT = 2;
`else
    localparam int RESP_LAT = 3;
`endif
    localparam logic [WW-1:0] SALT = 'h155;

    logic          clock = 1'b0;
    logic          reset;
    logic          code_req;
    logic [AW-1:0] code_addr;
    logic [WW-1:0] code_data;
    logic [WW-1:0] ip_to_call;
    logic          call_performed;
    logic [WW-1:0] ip_to_return;
    logic          return_performed;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] ip_out;
    logic [WW-1:0] instr_out;

    processor_fetch_queue #(
        .ADDR_SIZE(AW),
        .WORD_SIZE(WW),
        .DEPTH    (DEPTH)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .code_req        (code_req),
        .code_addr       (code_addr),
        .code_data       (code_data),
        .ip_to_call      (ip_to_call),
        .call_performed  (call_performed),
        .ip_to_return    (ip_to_return),
        .return_performed(return_performed),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .ip_out          (ip_out),
        .instr_out       (instr_out)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] ip;
        logic [WW-1:0] instr;
    } ent_t;

    typedef struct {
        int            hold;
        logic          rdy;
        logic          c;
        logic          r;
        logic [WW-1:0] tc;
        logic [WW-1:0] tr;
        logic [AW-1:0] e0;
        logic [AW-1:0] e1;
        logic [AW-1:0] e2;
    } vec_t;

    // Reference model: what the decoder should see, plus the read it is waiting on.
    ent_t          m_q[$];
    logic [AW-1:0] m_fetch_ip;
    logic [AW-1:0] m_pend_ip;
    bit            m_pend;
    bit            m_running;
    // Code memory: remembers last cycle's request to answer it this cycle.
    bit            mem_req;
    logic [AW-1:0] mem_addr;

    int errors = 0;
    int checks = 0;

    function automatic ent_t mk(input logic [AW-1:0] ip);
        return '{ip: ip, instr: WW'(ip) ^ SALT};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fetch_ip = '0;
        m_pend_ip  = '0;
        m_pend     = 1'b0;
        m_running  = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
    endtask

    // One clock period starting at a falling edge: drive, compare, advance the model.
    task automatic cycle(input logic rdy, input logic c, input logic r,
                         input logic [WW-1:0] tc, input logic [WW-1:0] tr,
                         output logic v, output logic [AW-1:0] ip);
        bit            redirect;
        bit            exp_valid;
        bit            exp_req;
        bit            pop;
        bit            bypass;
        ent_t          exp_head;
        logic [AW-1:0] tgt;

        out_ready        = rdy;
        call_performed   = c;
        return_performed = r;
        ip_to_call       = tc;
        ip_to_return     = tr;
        code_data        = mem_req ? (WW'(mem_addr) ^ SALT) : WW'($urandom);
        #1;

        redirect  = c || r;
        tgt       = r ? tr[AW-1:0] : tc[AW-1:0];
        bypass    = 1'b0;
        exp_valid = (m_q.size() != 0);
        exp_head  = exp_valid ? m_q[0] : '0;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (!exp_valid && m_pend && !redirect) begin
            bypass    = 1'b1;
            exp_valid = 1'b1;
            exp_head  = mk(m_pend_ip);
        end
`endif
        pop     = exp_valid && rdy;
        exp_req = m_running && !redirect &&
                  (int'(m_q.size()) + int'(m_pend) - int'(pop) < DEPTH);

        check("out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid) begin
            check("ip_out", 64'(ip_out), 64'(exp_head.ip));
            check("instr_out", 64'(instr_out), 64'(exp_head.instr));
        end
        check("code_req", 64'(code_req), 64'(exp_req));
        if (exp_req)
            check("code_addr", 64'(code_addr), 64'(m_fetch_ip));

        v        = out_valid;
        ip       = ip_out;
        mem_req  = code_req;
        mem_addr = code_addr;

        if (pop && !bypass)
            void'(m_q.pop_front());
        if (redirect) begin
            m_q.delete();
            m_pend     = 1'b0;
            m_fetch_ip = tgt;
        end else begin
            if (m_pend && !(bypass && pop))
                m_q.push_back(mk(m_pend_ip));
            m_pend    = exp_req;
            m_pend_ip = m_fetch_ip;
            if (exp_req)
                m_fetch_ip = m_fetch_ip + AW'(1);
        end
        m_running = 1'b1;
        @(negedge clock);
    endtask

    // Runs with out_ready=1 until the first valid output; returns cycles waited.
    task automatic wait_valid(output int k, output logic [AW-1:0] ip);
        logic v;
        k = 0;
        v = 1'b0;
        ip = '0;
        while (!v && k < 12) begin
            k++;
            cycle(1'b1, 1'b0, 1'b0, '0, '0, v, ip);
        end
    endtask

    vec_t vecs[5];

    initial begin
        logic          v;
        logic [AW-1:0] ip;
        int            k;

        vecs[0] = '{hold: 3,  rdy: 1'b0, c: 1'b1, r: 1'b0, tc: 'h00100, tr: 'h00000,
                    e0: 'h00100, e1: 'h00101, e2: 'h00102};
        vecs[1] = '{hold: 0,  rdy: 1'b1, c: 1'b1, r: 1'b1, tc: 'h00010, tr: 'h00020,
                    e0: 'h00020, e1: 'h00021, e2: 'h00022};
        vecs[2] = '{hold: 10, rdy: 1'b0, c: 1'b0, r: 1'b1, tc: 'h00000, tr: 'h3FFFF,
                    e0: 'h3FFFF, e1: 'h00000, e2: 'h00001};
        vecs[3] = '{hold: 1,  rdy: 1'b1, c: 1'b1, r: 1'b0, tc: 'h2AAAA, tr: 'h00005,
                    e0: 'h2AAAA, e1: 'h2AAAB, e2: 'h2AAAC};
        vecs[4] = '{hold: 2,  rdy: 1'b0, c: 1'b1, r: 1'b1, tc: 'h11111, tr: 'h3FFFE,
                    e0: 'h3FFFE, e1: 'h3FFFF, e2: 'h00000};

        reset            = 1'b0;
        out_ready        = 1'b0;
        call_performed   = 1'b0;
        return_performed = 1'b0;
        ip_to_call       = '0;
        ip_to_return     = '0;
        code_data        = '0;
        model_reset();

        repeat (2) @(negedge clock);
        check("reset_code_req", 64'(code_req), 64'(0));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_ip_out", 64'(ip_out), 64'(0));
        check("reset_instr_out", 64'(instr_out), 64'(0));

        // Release and stream: first entry after RESP_LAT cycles, then one per cycle.
        reset = 1'b1;
        wait_valid(k, ip);
        check("release_to_valid", 64'(k - 1), 64'(RESP_LAT));
        check("first_ip", 64'(ip), 64'(0));
        for (int i = 1; i < 6; i++) begin
            cycle(1'b1, 1'b0, 1'b0, '0, '0, v, ip);
            check("stream_valid", 64'(v), 64'(1));
            check("stream_ip", 64'(ip), 64'(i));
        end

        // Stall: queue fills to DEPTH, fetch stops, nothing is lost on release.
        repeat (10) cycle(1'b0, 1'b0, 1'b0, '0, '0, v, ip);
        check("stall_no_req", 64'(code_req), 64'(0));
        check("stall_valid", 64'(out_valid), 64'(1));
        for (int i = 0; i < DEPTH + 2; i++) begin
            cycle(1'b1, 1'b0, 1'b0, '0, '0, v, ip);
            check("drain_valid", 64'(v), 64'(1));
            check("drain_ip", 64'(ip), 64'(6 + i));
        end

        // Redirect vectors.
        for (int n = 0; n < 5; n++) begin
            for (int h = 0; h < vecs[n].hold; h++)
                cycle(1'b0, 1'b0, 1'b0, '0, '0, v, ip);
            cycle(vecs[n].rdy, vecs[n].c, vecs[n].r, vecs[n].tc, vecs[n].tr, v, ip);
            wait_valid(k, ip);
            check("redirect_latency", 64'(k), 64'(RESP_LAT));
            check("redirect_ip0", 64'(ip), 64'(vecs[n].e0));
            cycle(1'b1, 1'b0, 1'b0, '0, '0, v, ip);
            check("redirect_valid1", 64'(v), 64'(1));
            check("redirect_ip1", 64'(ip), 64'(vecs[n].e1));
            cycle(1'b1, 1'b0, 1'b0, '0, '0, v, ip);
            check("redirect_valid2", 64'(v), 64'(1));
            check("redirect_ip2", 64'(ip), 64'(vecs[n].e2));
        end

        // Asynchronous reset with a partly full queue and a read in flight.
        repeat (3) cycle(1'b1, 1'b0, 1'b0, '0, '0, v, ip);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, '0, '0, v, ip);
        check("pre_reset_valid", 64'(out_valid), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        check("async_code_req", 64'(code_req), 64'(0));
        check("async_out_valid", 64'(out_valid), 64'(0));
        check("async_ip_out", 64'(ip_out), 64'(0));
        check("async_instr_out", 64'(instr_out), 64'(0));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        model_reset();
        wait_valid(k, ip);
        check("restart_to_valid", 64'(k - 1), 64'(RESP_LAT));
        check("restart_ip", 64'(ip), 64'(0));

        // Randomized traffic: backpressure and occasional (sometimes simultaneous) redirects.
        for (int n = 0; n < 400; n++) begin
            int roll;
            roll = int'($urandom_range(0, 99));
            cycle(($urandom_range(0, 99) < 70), (roll < 4), (roll >= 2 && roll < 6),
                  WW'($urandom), WW'($urandom), v, ip);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
